irq_timer_bank: RTL
===================

IRQ_TIMER_BANK -- requirements
Module: irq_timer_bank

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, meaning number of independent timer channels (1..16).
REQ-002 The block SHALL have parameter WIDTH, default 16, meaning counter width in bits (2..32).
REQ-003 Port clk SHALL be input, 1 bit: clock; all logic on its rising edge.
REQ-004 Port RESET SHALL be input, 1 bit: reset, synchronous, active-high.
REQ-005 Port cfg_we SHALL be input, 1 bit: configuration write strobe, single-cycle.
REQ-006 Port cfg_ch SHALL be input, $clog2(NUM_CH) bits (min 1): target channel of the write.
REQ-007 Port cfg_reload SHALL be input, WIDTH bits: reload value R.
REQ-008 Port cfg_mode SHALL be input, 2 bits: 00 off, 01 one-shot, 10 periodic, 11 reserved (treated as off).
REQ-009 Port irq_ack SHALL be input, NUM_CH bits: per-channel interrupt clear.
REQ-010 Port irq SHALL be output, NUM_CH bits: per-channel sticky interrupt level.
REQ-011 Port overrun SHALL be output, NUM_CH bits: per-channel sticky missed-interrupt flag.
REQ-012 Port busy SHALL be output, NUM_CH bits: channel in RUN state.
REQ-013 Port count SHALL be output, NUM_CH*WIDTH bits: channel c's current counter at bits [c*WIDTH +: WIDTH].

Function
REQ-014 Each channel SHALL implement a state machine with states IDLE, RUN and DONE.
REQ-015 A write (cfg_we=1, cfg_ch=c) SHALL load count[c]<=R and latch mode on the next edge, entering RUN for one-shot/periodic and IDLE otherwise; irq/overrun are unaffected.
REQ-016 In RUN with count>0, count SHALL decrement by 1 per cycle.
REQ-017 In RUN with count==0 (expiry), irq SHALL be set on the next edge; periodic mode reloads count<=R and stays in RUN; one-shot goes to DONE with count held at 0.
REQ-018 Timing: write at edge t gives count=R after t, expiry cycle t+R, irq=1 after edge t+R+1; periodic period SHALL be R+1 cycles; R=0 gives expiry every cycle.
REQ-019 An expiry while irq[c] is already 1 and irq_ack[c]=0 SHALL set overrun[c].
REQ-020 irq_ack[c]=1 SHALL clear irq[c] and overrun[c] on the next edge; if expiry coincides, irq[c] SHALL end at 1 and overrun[c] at 0 (set wins over clear; no overrun counted).
REQ-021 A write to a RUN channel SHALL restart it from the new R; a write coinciding with that channel's expiry SHALL take precedence over the reload but SHALL still set irq.
REQ-022 Writes with cfg_ch >= NUM_CH SHALL be ignored.
REQ-023 IDLE and DONE SHALL hold count; busy[c]=1 only in RUN.
REQ-024 Channels SHALL be fully independent; simultaneous events on different channels SHALL be handled in the same cycle.

Reset
REQ-025 While RESET=1, all channels SHALL enter IDLE with count=all-ones, irq=0, overrun=0, busy=0, mode=off, overriding writes and acks.
REQ-026 A RESET asserted mid-count SHALL abort the channel with no expiry and no irq generated.

Structure
REQ-027 A package irq_timer_pkg SHALL hold the mode enum (MODE_OFF, MODE_ONESHOT, MODE_PERIODIC) and the state enum (IDLE, RUN, DONE).
REQ-028 One sub-module irq_timer_ch (single channel, parameter WIDTH) SHALL be instantiated NUM_CH times via generate; the top only decodes cfg_ch and concatenates outputs.

Verification
REQ-029 NUM_CH=4, WIDTH=16: write ch1 one-shot R=5 -> irq[1]=1 exactly 6 cycles after the write edge, count[1]=0, busy[1]=0, other channels untouched.
REQ-030 Write ch0 periodic R=3, never ack -> irq[0] after 4 cycles, overrun[0]=1 at the second expiry (cycle 8); ack -> both clear next cycle.
REQ-031 Periodic R=2 on ch2 with irq_ack[2] pulsed in an expiry cycle -> irq[2] stays 1, overrun[2]=0.
REQ-032 ch3 one-shot R=10, rewrite with R=2 at count=4 -> irq[3] 3 cycles after the rewrite, no earlier irq.
REQ-033 RESET asserted at count=1 on a running channel -> no irq, count=16'hFFFF, state IDLE; write with cfg_ch=5 (NUM_CH=4 with 3-bit cfg_ch) -> no channel changes.
REQ-034 Periodic R=0 on ch0 -> irq every cycle, overrun set from the second cycle while unacked.

Source files
------------

// File: rtl/irq_timer_pkg.sv
// irq_timer_pkg
// Shared types for the interrupt timer bank: the per-channel operating mode
// and the per-channel state machine encoding, plus a helper that turns the raw
// two-bit configuration mode field into a legal mode.
package irq_timer_pkg;

  typedef enum logic [1:0] {
    MODE_OFF      = 2'b00,
    MODE_ONESHOT  = 2'b01,
    MODE_PERIODIC = 2'b10
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // The reserved encoding 2'b11 behaves exactly like off.
  function automatic mode_t decode_mode(input logic [1:0] raw);
    mode_t m;
    case (raw)
      2'b01:   m = MODE_ONESHOT;
      2'b10:   m = MODE_PERIODIC;
      default: m = MODE_OFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/irq_timer_ch.sv
// irq_timer_ch
// One down-counting timer channel with a sticky interrupt and a sticky
// missed-interrupt (overrun) flag.
// Ports:
//   clk        - clock, rising edge
//   RESET      - synchronous active-high reset
//   cfg_we     - write strobe already decoded for this channel
//   cfg_reload - reload value R
//   cfg_mode   - raw mode field (00 off, 01 one-shot, 10 periodic, 11 off)
//   irq_ack    - clears irq and overrun
//   irq        - sticky interrupt level
//   overrun    - set when an expiry hits an unacknowledged irq
//   busy       - high while in RUN
//   count      - current counter value
module irq_timer_ch
  import irq_timer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_reload,
  input  logic [1:0]       cfg_mode,
  input  logic             irq_ack,
  output logic             irq,
  output logic             overrun,
  output logic             busy,
  output logic [WIDTH-1:0] count
);

  state_t           state, state_n;
  mode_t            mode, mode_n;
  logic [WIDTH-1:0] reload, reload_n;
  logic [WIDTH-1:0] count_q, count_n;
  logic             irq_q, irq_n;
  logic             overrun_q, overrun_n;
  logic             expire;

  assign expire = (state == RUN) && (count_q == '0);

  always_ff @(posedge clk) begin
    if (RESET) begin
      state     <= IDLE;
      mode      <= MODE_OFF;
      reload    <= '1;
      count_q   <= '1;
      irq_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state     <= state_n;
      mode      <= mode_n;
      reload    <= reload_n;
      count_q   <= count_n;
      irq_q     <= irq_n;
      overrun_q <= overrun_n;
    end
  end

  always_comb begin
    state_n   = state;
    mode_n    = mode;
    reload_n  = reload;
    count_n   = count_q;
    irq_n     = irq_q;
    overrun_n = overrun_q;

    case (state)
      RUN: begin
        if (count_q != '0) begin
          count_n = count_q - WIDTH'(1);
        end else if (mode == MODE_PERIODIC) begin
          count_n = reload;
        end else begin
          state_n = DONE;
          count_n = '0;
        end
      end
      default: ;
    endcase

    // A write overrides whatever the counter was about to do, including a
    // periodic reload in the expiry cycle; the expiry itself still counts.
    if (cfg_we) begin
      mode_n   = decode_mode(cfg_mode);
      reload_n = cfg_reload;
      count_n  = cfg_reload;
      state_n  = (decode_mode(cfg_mode) == MODE_OFF) ? IDLE : RUN;
    end

    // Expiry beats acknowledge; an ack in the expiry cycle consumes the old
    // interrupt so no overrun is recorded.
    if (expire) begin
      irq_n     = 1'b1;
      overrun_n = irq_ack ? 1'b0 : (overrun_q | irq_q);
    end else if (irq_ack) begin
      irq_n     = 1'b0;
      overrun_n = 1'b0;
    end
  end

  assign irq     = irq_q;
  assign overrun = overrun_q;
  assign busy    = (state == RUN);
  assign count   = count_q;

endmodule

// File: rtl/irq_timer_bank.sv
// irq_timer_bank
// Bank of NUM_CH independent interrupt timers. The top only decodes the
// configuration channel select and concatenates the per-channel outputs.
// Ports:
//   clk        - clock, rising edge
//   RESET      - synchronous active-high reset
//   cfg_we     - configuration write strobe
//   cfg_ch     - target channel; values >= NUM_CH are ignored
//   cfg_reload - reload value R
//   cfg_mode   - 00 off, 01 one-shot, 10 periodic, 11 off
//   irq_ack    - per-channel interrupt clear
//   irq        - per-channel sticky interrupt
//   overrun    - per-channel sticky missed-interrupt flag
//   busy       - per-channel RUN indicator
//   count      - channel c counter at [c*WIDTH +: WIDTH]
// CH_W defaults to the minimum select width and may be widened so that
// out-of-range channel numbers can be presented.
module irq_timer_bank
  import irq_timer_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 16,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    RESET,
  input  logic                    cfg_we,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic [WIDTH-1:0]        cfg_reload,
  input  logic [1:0]              cfg_mode,
  input  logic [NUM_CH-1:0]       irq_ack,
  output logic [NUM_CH-1:0]       irq,
  output logic [NUM_CH-1:0]       overrun,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH*WIDTH-1:0] count
);

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic ch_we;

      // Exact match only, so selects beyond the last channel write nothing.
      assign ch_we = cfg_we && (cfg_ch == CH_W'(c));

      irq_timer_ch #(
        .WIDTH(WIDTH)
      ) u_ch (
        .clk        (clk),
        .RESET      (RESET),
        .cfg_we     (ch_we),
        .cfg_reload (cfg_reload),
        .cfg_mode   (cfg_mode),
        .irq_ack    (irq_ack[c]),
        .irq        (irq[c]),
        .overrun    (overrun[c]),
        .busy       (busy[c]),
        .count      (count[c*WIDTH +: WIDTH])
      );
    end
  endgenerate

endmodule
